// File: rtl/nivel2_timer_contagem_pkg.sv
// nivel2_timer_contagem_pkg
// Shared definitions for the cook-time countdown timer.
// Contents:
//   - state_t : controller state encodings.
//   - BCD_0, BCD_5, BCD_9 : BCD constants used for zero detection,
//     digit wrap values and keypad digit validation.
package nivel2_timer_contagem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADED   = 2'd1,
    ST_COUNTING = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [3:0] BCD_0 = 4'd0;
  localparam logic [3:0] BCD_5 = 4'd5;
  localparam logic [3:0] BCD_9 = 4'd9;

endpackage

// File: rtl/nivel2_bcd_digito_desc.sv
// nivel2_bcd_digito_desc
// One BCD down-counting digit. Digits are chained by borrow to build
// a multi-digit countdown.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset (q -> 0)
//   en       : decrement enable for this cycle
//   load     : load load_val (takes priority over en)
//   load_val : value to load
//   wrap_val : value taken when decrementing from 0 (9 or 5)
//   q        : current digit
//   borrow   : high when this digit wraps (q==0 while enabled)
module nivel2_bcd_digito_desc
  import nivel2_timer_contagem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic [3:0] wrap_val,
  output logic [3:0] q,
  output logic       borrow
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= BCD_0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= (q == BCD_0) ? wrap_val : q - 4'd1;
    end
  end

  assign borrow = en && (q == BCD_0);

endmodule

// File: rtl/nivel2_timer_contagem.sv
// nivel2_timer_contagem
// Microwave cook-time countdown timer (MM:SS, BCD). Accepts keypad
// digit entry by shifting left, counts down once per tick_1hz while
// the magnetron is on, and raises timer_done when 00:00 is reached.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   tick_1hz      : one-cycle count enable, once per second
//   mag_on        : magnetron-on level
//   clear         : synchronous clear of the cook time
//   digit_valid   : strobe qualifying digit
//   digit         : BCD keypad digit
//   sec_ones .. min_tens : current time, BCD, registered
//   zero          : all digits are 0 (registered)
//   timer_done    : high in DONE (registered)
module nivel2_timer_contagem
  import nivel2_timer_contagem_pkg::*;
#(
  parameter int MAX_MIN_TENS = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       mag_on,
  input  logic       clear,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       zero,
  output logic       timer_done
);

  localparam logic [3:0] MAX_MT = 4'(MAX_MIN_TENS);

  state_t     state_q;
  logic       zero_q;
  logic       done_q;
  logic [3:0] so_q, st_q, mo_q, mt_q;
  logic       so_b, st_b, mo_b, mt_b;

  logic entry_ok;
  logic entry_zero;
  logic dec;
  logic at_one;
  logic load;

  // min_ones becomes min_tens on entry, so it is what the limit gates.
  assign entry_ok = !clear && digit_valid && (state_q != ST_COUNTING) &&
                    (digit <= BCD_9) && (mo_q <= MAX_MT);
  assign entry_zero = (st_q == BCD_0) && (so_q == BCD_0) &&
                      (mo_q == BCD_0) && (digit == BCD_0);
  // A tick only counts while already COUNTING with mag_on still high.
  assign dec = !clear && (state_q == ST_COUNTING) && mag_on && tick_1hz;
  assign at_one = (mt_q == BCD_0) && (mo_q == BCD_0) &&
                  (st_q == BCD_0) && (so_q == 4'd1);
  // Clear is implemented as a load of zeros.
  assign load = clear || entry_ok;

  nivel2_bcd_digito_desc u_sec_ones (
    .clk(clk), .rst(rst), .en(dec), .load(load),
    .load_val(clear ? BCD_0 : digit), .wrap_val(BCD_9),
    .q(so_q), .borrow(so_b)
  );

  nivel2_bcd_digito_desc u_sec_tens (
    .clk(clk), .rst(rst), .en(so_b), .load(load),
    .load_val(clear ? BCD_0 : so_q), .wrap_val(BCD_5),
    .q(st_q), .borrow(st_b)
  );

  nivel2_bcd_digito_desc u_min_ones (
    .clk(clk), .rst(rst), .en(st_b), .load(load),
    .load_val(clear ? BCD_0 : st_q), .wrap_val(BCD_9),
    .q(mo_q), .borrow(mo_b)
  );

  nivel2_bcd_digito_desc u_min_tens (
    .clk(clk), .rst(rst), .en(mo_b), .load(load),
    .load_val(clear ? BCD_0 : mo_q), .wrap_val(BCD_9),
    .q(mt_q), .borrow(mt_b)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= ST_IDLE;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (entry_ok) begin
            state_q <= entry_zero ? ST_IDLE : ST_LOADED;
            zero_q  <= entry_zero;
            done_q  <= 1'b0;
          end
        end
        ST_LOADED: begin
          if (entry_ok) begin
            state_q <= entry_zero ? ST_IDLE : ST_LOADED;
            zero_q  <= entry_zero;
          end else if (mag_on) begin
            state_q <= ST_COUNTING;
          end
        end
        ST_COUNTING: begin
          if (!mag_on) begin
            state_q <= ST_LOADED;
          end else if (dec) begin
            // mt_b marks a wrap past 00:00; stop there rather than
            // keep running on a wrapped time.
            if (at_one || mt_b) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
            zero_q <= at_one;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sec_ones   = so_q;
  assign sec_tens   = st_q;
  assign min_ones   = mo_q;
  assign min_tens   = mt_q;
  assign zero       = zero_q;
  assign timer_done = done_q;

endmodule

// File: doc/nivel2_timer_contagem.md
# nivel2_timer_contagem

Countdown timer stage directly upstream of the magnetron control: holds the cook time as four BCD digits (MM:SS), accepts keypad digit entry, counts down once per 1 Hz tick while the magnetron is on, and raises `timer_done`, which the magnetron control consumes to switch the magnetron off. Digit outputs also drive the display stage.

## Interface
Parameters:
- `MAX_MIN_TENS`, 9, maximum accepted value for the minutes-tens digit; larger entries are ignored.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tick_1hz`  in  1  one-`clk`-wide count enable, one pulse per second.
- `mag_on`  in  1  magnetron-on level from magnetron control.
- `clear`  in  1  synchronous clear of the cook time (keypad CLEAR, active-high).
- `digit_valid`  in  1  one-cycle strobe: `digit` holds a new keypad digit.
- `digit`  in  4  BCD digit from keypad.
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`  out  4 each  current time, BCD, registered.
- `zero`  out  1  high when all four digits are 0.
- `timer_done`  out  1  high in state DONE only.

## Operation
- States: IDLE (time 00:00, not started), LOADED (nonzero, paused), COUNTING, DONE.
- Per-cycle priority: `rst` > `clear` > state action.
- `rst` or `clear`: all digits 0, state IDLE, `timer_done`=0, `zero`=1.
- Digit entry (IDLE, LOADED, DONE only), when `digit_valid`=1 and `digit`≤9: shift left — `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`digit`. Entry of `digit`>9 is dropped. Entry that would make `min_tens` > `MAX_MIN_TENS` is dropped whole. After accepted entry: LOADED if result nonzero, else IDLE. Entry ignored in COUNTING.
- LOADED → COUNTING when `mag_on`=1. COUNTING → LOADED when `mag_on`=0 (pause; digits held).
- In COUNTING, on `tick_1hz`=1 with `mag_on`=1: decrement by one second, BCD:
  - `sec_ones`>0: `sec_ones`−1.
  - else `sec_ones`=9; `sec_tens`>0: `sec_tens`−1.
  - else `sec_tens`=5; borrow into minutes the same way (`min_ones` 0→9 borrows from `min_tens`).
  - `sec_tens` values 6–9 from entry are legal and count down normally (1:90 → 1:89).
- Decrement reaching 00:00 → DONE. DONE holds until `clear`, `rst`, or accepted digit entry (→ LOADED/IDLE). `mag_on` ignored in IDLE and DONE.

## Timing
- All outputs registered; every output reflects the state one cycle after the causing edge.
- Reset values: all digits 0, `zero`=1, `timer_done`=0, state IDLE.
- Entering COUNTING takes one cycle; a `tick_1hz` on the same cycle `mag_on` rises in LOADED is ignored.
- `tick_1hz` on the cycle `mag_on` falls in COUNTING is ignored (pause wins).
- `tick_1hz` coinciding with `clear` is ignored; `digit_valid` coinciding with `clear` is ignored.
- `timer_done` rises on the edge where the final 00:01→00:00 decrement is registered; `zero` rises on the same edge.
- `timer_done` is a level, not a pulse; magnetron control drops `mag_on` in response, which has no effect in DONE.

## Structure
- Shared include header (nivel2 timer defines): state encodings (IDLE=2'd0, LOADED=2'd1, COUNTING=2'd2, DONE=2'd3), BCD constants 0/5/9.
- Sub-module `nivel2_bcd_digito_desc`: one BCD down-digit with `en`, `load`, `load_val`, `wrap_val` (9 or 5), outputs `q` and `borrow` (q==0 & en). Four instances chained by borrow; shift-load muxed in top level.

## Test plan
- Reset: `rst`=1 one cycle with `digit_valid`=1 → digits 0000, `zero`=1, `timer_done`=0, state IDLE.
- Entry: digits 1,3,0 → display 01:30, state LOADED; then `digit`=12 → unchanged 01:30.
- Countdown: load 00:03, `mag_on`=1, 3 ticks → 00:02, 00:01, 00:00; `timer_done`=1 on edge after third tick.
- Borrow: load 10:00, one tick in COUNTING → 09:59; load 01:90, one tick → 01:89.
- Pause/simultaneity: COUNTING at 00:45, drop `mag_on` with tick same cycle → stays 00:45, LOADED; raise `mag_on` with tick same cycle → still 00:45, next tick → 00:44.
- Clear and DONE exit: in COUNTING at 02:10 assert `clear` with tick → 00:00, IDLE, `timer_done`=0; from DONE enter digit 5 → 00:05, LOADED, `timer_done`=0.
